// File: rtl/param_dp_ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package param_dp_ram_pkg;

    // Init sequencer states: INIT fills the array, READY serves traffic.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } dpram_state_e;

    // Cross-port read-during-write policy encodings for RDW_MODE.
    localparam int RDW_OLD_DATA = 0;
    localparam int RDW_NEW_DATA = 1;

    // Even parity of one byte: stored bit makes the 9-bit total even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // Byte merge: take the new byte where its enable is set, else keep old.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/param_dp_ram_rdpipe.sv
// Per-port read pipeline: registers read word, valid strobe and parity error.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from accepted read.
// Backpressure: none; accepts one read per cycle, rdata holds while rvalid=0.
module param_dp_ram_rdpipe
    import param_dp_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_acc,
    input  logic [DATA_W-1:0] rd_word,
    input  logic              rd_err,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              perr
);

    logic              s1_vld;
    logic              s1_err;
    logic [DATA_W-1:0] s1_dat;

    // First stage: capture the array word on an accepted read, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_err <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_dat <= rd_word;
                s1_err <= rd_err;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_vld;
            logic              s2_err;
            logic [DATA_W-1:0] s2_dat;

            // Optional output register: forwards stage one only when it is valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_vld <= 1'b0;
                    s2_err <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                        s2_err <= s1_err;
                    end
                end
            end

            assign rdata  = s2_dat;
            assign rvalid = s2_vld;
            assign perr   = s2_vld & s2_err;
        end else begin : g_no_out_reg
            assign rdata  = s1_dat;
            assign rvalid = s1_vld;
            assign perr   = s1_vld & s1_err;
        end
    endgenerate

endmodule

// File: rtl/param_dp_ram.sv
// True dual-port RAM, byte enables, self-initialising after reset; optional byte parity via PDPRAM_PARITY_EN.
// Latency: read data 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); busy for 2**ADDR_W cycles after reset.
// Backpressure: none; requests arriving while busy=1 are silently dropped.
module param_dp_ram
    import param_dp_ram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                OUT_REG  = 0,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_rvalid,
    output logic                  a_perr,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [DATA_W/8-1:0]   b_be,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid,
    output logic                  b_perr,
    output logic                  busy,
    output logic                  coll
);

    localparam int BE_W    = DATA_W / 8;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit RDW_NEW = (RDW_MODE == RDW_NEW_DATA);

    dpram_state_e      state;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic a_wr, a_rd, b_wr, b_rd;
    logic wr_same, a_hit, b_hit;
    logic [DATA_W-1:0] a_old, b_old, a_word, b_word;
    logic a_err, b_err;

    assign busy = (state == ST_INIT);

    assign a_wr = a_en &  a_we & ~busy;
    assign a_rd = a_en & ~a_we & ~busy;
    assign b_wr = b_en &  b_we & ~busy;
    assign b_rd = b_en & ~b_we & ~busy;

    // Both ports writing one word; A owns any byte both enable.
    assign wr_same = a_wr & b_wr & (a_addr == b_addr);
    // A port reading the word the other port is writing this cycle.
    assign a_hit   = b_wr & (a_addr == b_addr);
    assign b_hit   = a_wr & (a_addr == b_addr);

    // Init sequencer: walk every address once, then stay READY until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                state <= ST_READY;
            end
        end
    end

    // Collision flag: one-cycle pulse after a same-address dual write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll <= 1'b0;
        end else begin
            coll <= wr_same;
        end
    end

    // Array update: init fill, else per-byte writes with A winning shared bytes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[init_cnt] <= INIT_VAL;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (a_wr && a_be[i]) begin
                    mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
                if (b_wr && b_be[i] && !(wr_same && a_be[i])) begin
                    mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read words: pre-write contents, optionally overlaid with the other port's write.
    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];

    for (genvar g = 0; g < BE_W; g++) begin : g_rd_byte
        assign a_word[g*8 +: 8] = merge_byte(a_old[g*8 +: 8], b_wdata[g*8 +: 8],
                                             RDW_NEW && a_hit && b_be[g]);
        assign b_word[g*8 +: 8] = merge_byte(b_old[g*8 +: 8], a_wdata[g*8 +: 8],
                                             RDW_NEW && b_hit && a_be[g]);
    end

`ifdef PDPRAM_PARITY_EN
    logic [BE_W-1:0] par_mem [DEPTH];
    logic [BE_W-1:0] init_par, a_par_bad, b_par_bad;

    // Bytes replaced by a forwarded write carry fresh data, so they cannot flag.
    for (genvar g = 0; g < BE_W; g++) begin : g_par_byte
        assign init_par[g]  = byte_parity(INIT_VAL[g*8 +: 8]);
        assign a_par_bad[g] = (par_mem[a_addr][g] ^ byte_parity(a_old[g*8 +: 8]))
                              & ~(RDW_NEW && a_hit && b_be[g]);
        assign b_par_bad[g] = (par_mem[b_addr][g] ^ byte_parity(b_old[g*8 +: 8]))
                              & ~(RDW_NEW && b_hit && a_be[g]);
    end

    // Parity array update: tracks the data array byte for byte.
    always_ff @(posedge clk) begin
        if (busy) begin
            par_mem[init_cnt] <= init_par;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (a_wr && a_be[i]) begin
                    par_mem[a_addr][i] <= byte_parity(a_wdata[i*8 +: 8]);
                end
                if (b_wr && b_be[i] && !(wr_same && a_be[i])) begin
                    par_mem[b_addr][i] <= byte_parity(b_wdata[i*8 +: 8]);
                end
            end
        end
    end

    assign a_err = |a_par_bad;
    assign b_err = |b_par_bad;
`else
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    param_dp_ram_rdpipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_rdpipe_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_acc  (a_rd),
        .rd_word (a_word),
        .rd_err  (a_err),
        .rdata   (a_rdata),
        .rvalid  (a_rvalid),
        .perr    (a_perr)
    );

    param_dp_ram_rdpipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_rdpipe_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_acc  (b_rd),
        .rd_word (b_word),
        .rd_err  (b_err),
        .rdata   (b_rdata),
        .rvalid  (b_rvalid),
        .perr    (b_perr)
    );

endmodule

// File: tb/tb_param_dp_ram.sv
// Bench for param_dp_ram: two instances (latency 1 / old-data, latency 2 / new-data) on shared stimulus.
// Latency: expectations come from a word-level memory model plus per-instance output delay.
// Backpressure: n/a; every request is issued on a fixed cycle schedule.
module tb_param_dp_ram;

    localparam int            DW    = 16;
    localparam int            AW    = 4;
    localparam int            BW    = 2;
    localparam int            DEPTH = 16;
    localparam logic [DW-1:0] INIT  = 16'h5A3C;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic          a_en, a_we, b_en, b_we;
    logic [BW-1:0] a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;

    logic [DW-1:0] a_rdata [2];
    logic [DW-1:0] b_rdata [2];
    logic          a_rvalid [2];
    logic          b_rvalid [2];
    logic          a_perr [2];
    logic          b_perr [2];
    logic          busy [2];
    logic          coll [2];

    param_dp_ram #(
        .DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(0), .INIT_VAL(INIT)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]), .a_perr(a_perr[0]),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]), .b_perr(b_perr[0]),
        .busy(busy[0]), .coll(coll[0])
    );

    param_dp_ram #(
        .DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(1), .INIT_VAL(INIT)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]), .a_perr(a_perr[1]),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]), .b_perr(b_perr[1]),
        .busy(busy[1]), .coll(coll[1])
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int            edges;
    logic          busy_m;
    logic [DW-1:0] mem_m [DEPTH];
    logic          corrupt;
    logic          e_a_vld [2];
    logic          e_b_vld [2];
    logic          e_a_err [2];
    logic          e_b_err [2];
    logic [DW-1:0] e_a_dat [2];
    logic [DW-1:0] e_b_dat [2];
    logic          q_a_vld, q_b_vld, q_a_err, q_b_err;
    logic [DW-1:0] q_a_dat, q_b_dat;

    function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] o,
                                              input logic [DW-1:0] n,
                                              input logic [BW-1:0] be);
        logic [DW-1:0] m;
        m = {{8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic chk1(input int d, input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s t=%0t observed=%b expected=%b", d, tag, $time, obs, exp);
        end
    endtask

    task automatic chkw(input int d, input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s t=%0t observed=%h expected=%h", d, tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input logic coll_e);
        for (int d = 0; d < 2; d++) begin
            chk1(d, "busy",     busy[d],     busy_m);
            chk1(d, "coll",     coll[d],     coll_e);
            chk1(d, "a_rvalid", a_rvalid[d], e_a_vld[d]);
            chkw(d, "a_rdata",  a_rdata[d],  e_a_dat[d]);
            chk1(d, "a_perr",   a_perr[d],   e_a_err[d]);
            chk1(d, "b_rvalid", b_rvalid[d], e_b_vld[d]);
            chkw(d, "b_rdata",  b_rdata[d],  e_b_dat[d]);
            chk1(d, "b_perr",   b_perr[d],   e_b_err[d]);
        end
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic drv_a(input logic en, input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] d);
        a_en = en; a_we = we; a_be = be; a_addr = addr; a_wdata = d;
    endtask

    task automatic drv_b(input logic en, input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] d);
        b_en = en; b_we = we; b_be = be; b_addr = addr; b_wdata = d;
    endtask

    task automatic model_reset();
        edges   = 0;
        busy_m  = 1'b1;
        corrupt = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
        for (int d = 0; d < 2; d++) begin
            e_a_vld[d] = 1'b0; e_b_vld[d] = 1'b0;
            e_a_err[d] = 1'b0; e_b_err[d] = 1'b0;
            e_a_dat[d] = '0;   e_b_dat[d] = '0;
        end
        q_a_vld = 1'b0; q_b_vld = 1'b0; q_a_err = 1'b0; q_b_err = 1'b0;
        q_a_dat = '0;   q_b_dat = '0;
    endtask

    // One clock of traffic: predict from the model, advance, then compare.
    task automatic step();
        logic          a_wr, a_rd, b_wr, b_rd, coll_e, ra_err, rb_err;
        logic [DW-1:0] ra_old, ra_new, rb_old, rb_new;
        a_wr = !busy_m && a_en &&  a_we;
        a_rd = !busy_m && a_en && !a_we;
        b_wr = !busy_m && b_en &&  b_we;
        b_rd = !busy_m && b_en && !b_we;
        ra_old = mem_m[a_addr];
        rb_old = mem_m[b_addr];
        ra_new = (b_wr && b_addr == a_addr) ? merge_m(ra_old, b_wdata, b_be) : ra_old;
        rb_new = (a_wr && a_addr == b_addr) ? merge_m(rb_old, a_wdata, a_be) : rb_old;
        ra_err = corrupt && (a_addr == 4'd2);
        rb_err = corrupt && (b_addr == 4'd2);
        coll_e = a_wr && b_wr && (a_addr == b_addr);
        // B first, then A, so A owns bytes both ports enable.
        if (b_wr) mem_m[b_addr] = merge_m(mem_m[b_addr], b_wdata, b_be);
        if (a_wr) mem_m[a_addr] = merge_m(mem_m[a_addr], a_wdata, a_be);
        if ((a_wr && a_addr == 4'd2 && a_be[0]) || (b_wr && b_addr == 4'd2 && b_be[0]))
            corrupt = 1'b0;
        @(posedge clk);
        edges++;
        busy_m = (edges < DEPTH);
        e_a_vld[0] = a_rd; e_a_err[0] = a_rd && ra_err;
        if (a_rd) e_a_dat[0] = ra_old;
        e_b_vld[0] = b_rd; e_b_err[0] = b_rd && rb_err;
        if (b_rd) e_b_dat[0] = rb_old;
        e_a_vld[1] = q_a_vld; e_a_err[1] = q_a_vld && q_a_err;
        if (q_a_vld) e_a_dat[1] = q_a_dat;
        e_b_vld[1] = q_b_vld; e_b_err[1] = q_b_vld && q_b_err;
        if (q_b_vld) e_b_dat[1] = q_b_dat;
        q_a_vld = a_rd; q_a_dat = ra_new; q_a_err = ra_err;
        q_b_vld = b_rd; q_b_dat = rb_new; q_b_err = rb_err;
        #1;
        check_all(coll_e);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk1(d, "rst a_rvalid", a_rvalid[d], 1'b0);
            chk1(d, "rst b_rvalid", b_rvalid[d], 1'b0);
            chkw(d, "rst a_rdata",  a_rdata[d],  16'h0000);
            chkw(d, "rst b_rdata",  b_rdata[d],  16'h0000);
            chk1(d, "rst busy",     busy[d],     1'b1);
            chk1(d, "rst coll",     coll[d],     1'b0);
            chk1(d, "rst a_perr",   a_perr[d],   1'b0);
            chk1(d, "rst b_perr",   b_perr[d],   1'b0);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk1(d, "rst hold busy",     busy[d],     1'b1);
            chk1(d, "rst hold a_rvalid", a_rvalid[d], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        idle();
        model_reset();
        #2;
        do_reset();

        // Init phase: reads and writes are dropped, busy for exactly DEPTH edges.
        for (int i = 0; i < DEPTH; i++) begin
            drv_a(1'b1, 1'b0, 2'b00, AW'(i), 16'h0000);
            drv_b(1'b1, 1'b1, 2'b11, 4'd1, 16'hDEAD);
            step();
        end

        // Whole array reads back the init constant.
        for (int i = 0; i < DEPTH; i++) begin
            drv_a(1'b1, 1'b0, 2'b00, AW'(i), 16'h0000);
            drv_b(1'b1, 1'b0, 2'b00, AW'(DEPTH - 1 - i), 16'h0000);
            step();
        end
        idle(); step(); step();

        // Cross-port write then read.
        drv_a(1'b1, 1'b1, 2'b11, 4'd5, 16'h1234); step();
        idle(); drv_b(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000); step();
        idle(); step(); step();

        // Partial byte write.
        drv_a(1'b1, 1'b1, 2'b11, 4'd3, 16'hAAAA); step();
        drv_a(1'b1, 1'b1, 2'b01, 4'd3, 16'h5555); step();
        drv_a(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000); step();
        idle(); step(); step();

        // be=0 write leaves the word untouched.
        drv_a(1'b1, 1'b1, 2'b00, 4'd5, 16'hFFFF); step();
        drv_a(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000); step();
        idle(); step(); step();

        // Same-address dual writes: full overlap, then disjoint bytes.
        drv_a(1'b1, 1'b1, 2'b11, 4'd7, 16'h1111);
        drv_b(1'b1, 1'b1, 2'b11, 4'd7, 16'h2222); step();
        idle(); drv_a(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000); step();
        idle(); step(); step();
        drv_a(1'b1, 1'b1, 2'b10, 4'd7, 16'h1111);
        drv_b(1'b1, 1'b1, 2'b01, 4'd7, 16'h2222); step();
        idle(); drv_b(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000); step();
        idle(); step(); step();

        // Read-during-write on the other port.
        drv_a(1'b1, 1'b1, 2'b11, 4'd9, 16'h0000); step();
        drv_a(1'b1, 1'b1, 2'b11, 4'd9, 16'hBEEF);
        drv_b(1'b1, 1'b0, 2'b00, 4'd9, 16'h0000); step();
        idle(); drv_a(1'b1, 1'b0, 2'b00, 4'd9, 16'h0000); step();
        idle(); step(); step();

        // Random traffic over a small address window to force overlaps.
        for (int i = 0; i < 400; i++) begin
            drv_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), 16'($urandom));
            drv_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), 16'($urandom));
            step();
        end
        idle(); step(); step();

`ifdef PDPRAM_PARITY_EN
        // Flip a stored data bit behind the parity array's back.
        dut0.mem[2] = dut0.mem[2] ^ 16'h0001;
        dut1.mem[2] = dut1.mem[2] ^ 16'h0001;
        mem_m[2] = mem_m[2] ^ 16'h0001;
        corrupt = 1'b1;
        drv_a(1'b1, 1'b0, 2'b00, 4'd2, 16'h0000); step();
        idle(); step(); step();
`endif

        // Reset in the middle of a read burst.
        for (int i = 0; i < 3; i++) begin
            drv_a(1'b1, 1'b0, 2'b00, AW'(i + 5), 16'h0000);
            drv_b(1'b1, 1'b0, 2'b00, AW'(i + 7), 16'h0000);
            step();
        end
        do_reset();

        // Init restarts and earlier writes are wiped.
        for (int i = 0; i < DEPTH; i++) begin
            drv_a(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
            idle();
            if (i % 2 == 0) drv_a(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
            step();
        end
        drv_a(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
        drv_b(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000); step();
        drv_a(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
        drv_b(1'b1, 1'b0, 2'b00, 4'd9, 16'h0000); step();
        idle(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
